// File: rtl/wb_arbiter_if.sv
// Write-back arbiter bus: producer results in, complete-stage lanes out.
//
// Handshake: a producer result transfers into its source FIFO at a rising
// clock edge exactly when src_valid_i[s] && src_ready_o[s]. src_ready_o is
// derived only from registered FIFO occupancy, so it never depends on
// src_valid_i in the same cycle, and a producer may hold src_valid_i with
// stable payload until it sees the transfer. Output lanes carry no back
// pressure: a lane with fu_valid_o set is consumed in that cycle.
interface wb_arbiter_if #(
  parameter int XLEN      = 32,
  parameter int PHYS_REGS = 128,
  parameter int ROB_DEPTH = 64,
  parameter int WB_WIDTH  = 4,
  parameter int NUM_SRC   = 6
);
  localparam int TAG_W = $clog2(PHYS_REGS);
  localparam int ROB_W = $clog2(ROB_DEPTH);
  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                              flush_i;
  logic [NUM_SRC-1:0]                src_valid_i;
  logic [NUM_SRC-1:0]                src_ready_o;
  logic [NUM_SRC-1:0][XLEN-1:0]      src_value_i;
  logic [NUM_SRC-1:0][TAG_W-1:0]     src_dest_i;
  logic [NUM_SRC-1:0][ROB_W-1:0]     src_rob_i;
  logic [NUM_SRC-1:0]                src_exc_i;
  logic [NUM_SRC-1:0]                src_mispred_i;

  logic [WB_WIDTH-1:0]               fu_valid_o;
  logic [WB_WIDTH-1:0][XLEN-1:0]     fu_value_o;
  logic [WB_WIDTH-1:0][TAG_W-1:0]    fu_dest_prf_o;
  logic [WB_WIDTH-1:0][ROB_W-1:0]    fu_rob_idx_o;
  logic [WB_WIDTH-1:0]               fu_exception_o;
  logic [WB_WIDTH-1:0]               fu_mispred_o;

  // Round-robin scan start, exposed for observation.
  logic [PTR_W-1:0]                  dbg_rr_ptr;

  // Arbiter side.
  modport slave (
    input  flush_i, src_valid_i, src_value_i, src_dest_i, src_rob_i,
           src_exc_i, src_mispred_i,
    output src_ready_o, fu_valid_o, fu_value_o, fu_dest_prf_o, fu_rob_idx_o,
           fu_exception_o, fu_mispred_o, dbg_rr_ptr
  );

  // Producer / complete-stage side.
  modport master (
    output flush_i, src_valid_i, src_value_i, src_dest_i, src_rob_i,
           src_exc_i, src_mispred_i,
    input  src_ready_o, fu_valid_o, fu_value_o, fu_dest_prf_o, fu_rob_idx_o,
           fu_exception_o, fu_mispred_o, dbg_rr_ptr
  );
endinterface

// File: rtl/wb_arbiter.sv
// Write-back arbiter: per-source skid FIFOs feeding WB_WIDTH packed lanes,
// granted round-robin starting at rr_ptr. One lane per source per cycle.
module wb_arbiter #(
  parameter int XLEN      = 32,
  parameter int PHYS_REGS = 128,
  parameter int ROB_DEPTH = 64,
  parameter int WB_WIDTH  = 4,
  parameter int NUM_SRC   = 6,
  parameter int BUF_DEPTH = 2
) (
  input logic         clock,
  input logic         reset,
  wb_arbiter_if.slave bus
);
  localparam int TAG_W  = $clog2(PHYS_REGS);
  localparam int ROB_W  = $clog2(ROB_DEPTH);
  localparam int PTR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int BPTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int LANE_W = (WB_WIDTH > 1) ? $clog2(WB_WIDTH) : 1;

  typedef struct packed {
    logic [XLEN-1:0]  value;
    logic [TAG_W-1:0] dest;
    logic [ROB_W-1:0] rob;
    logic             exc;
    logic             mispred;
  } entry_t;

  entry_t            mem    [NUM_SRC][BUF_DEPTH];
  logic [BPTR_W-1:0] wr_ptr [NUM_SRC];
  logic [BPTR_W-1:0] rd_ptr [NUM_SRC];
  logic [CNT_W-1:0]  count  [NUM_SRC];
  entry_t            head   [NUM_SRC];

  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   next_rr;
  logic               any_grant;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] ready;
  logic [NUM_SRC-1:0] push;
  logic [NUM_SRC-1:0] grant;

  logic [WB_WIDTH-1:0]            lane_valid;
  logic [WB_WIDTH-1:0][XLEN-1:0]  lane_value;
  logic [WB_WIDTH-1:0][TAG_W-1:0] lane_dest;
  logic [WB_WIDTH-1:0][ROB_W-1:0] lane_rob;
  logic [WB_WIDTH-1:0]            lane_exc;
  logic [WB_WIDTH-1:0]            lane_mispred;

  // Advance a FIFO pointer, wrapping at BUF_DEPTH.
  function automatic logic [BPTR_W-1:0] bump(input logic [BPTR_W-1:0] p);
    return (p == BPTR_W'(BUF_DEPTH - 1)) ? '0 : p + BPTR_W'(1);
  endfunction

  // Per-source occupancy status, accepted pushes and FIFO head read.
  always_comb begin
    for (int s = 0; s < NUM_SRC; s++) begin
      eligible[s] = (count[s] != '0);
      ready[s]    = (count[s] != CNT_W'(BUF_DEPTH));
      push[s]     = bus.src_valid_i[s] && ready[s] && !bus.flush_i;
      head[s]     = mem[s][rd_ptr[s]];
    end
  end

  // Round-robin scan from rr_ptr packing eligible heads onto lanes 0,1,2...
  // Lanes only ever see a head whose FIFO is non-empty, so stale or unknown
  // storage cannot leak out; unused lanes stay at zero.
  always_comb begin
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  last;
    logic [LANE_W-1:0] lane;
    logic              lanes_full;
    grant        = '0;
    lane_valid   = '0;
    lane_value   = '0;
    lane_dest    = '0;
    lane_rob     = '0;
    lane_exc     = '0;
    lane_mispred = '0;
    idx          = rr_ptr;
    last         = rr_ptr;
    lane         = '0;
    lanes_full   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (!bus.flush_i && eligible[idx] && !lanes_full) begin
        grant[idx]         = 1'b1;
        last               = idx;
        lane_valid[lane]   = 1'b1;
        lane_value[lane]   = head[idx].value;
        lane_dest[lane]    = head[idx].dest;
        lane_rob[lane]     = head[idx].rob;
        lane_exc[lane]     = head[idx].exc;
        lane_mispred[lane] = head[idx].mispred;
        if (lane == LANE_W'(WB_WIDTH - 1)) lanes_full = 1'b1;
        else lane = lane + LANE_W'(1);
      end
      idx = (idx == PTR_W'(NUM_SRC - 1)) ? '0 : idx + PTR_W'(1);
    end
    any_grant = |grant;
    next_rr   = (last == PTR_W'(NUM_SRC - 1)) ? '0 : last + PTR_W'(1);
  end

  // FIFO storage writes; contents need no reset because occupancy gates reads.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (push[s]) begin
        mem[s][wr_ptr[s]] <= '{value:   bus.src_value_i[s],
                               dest:    bus.src_dest_i[s],
                               rob:     bus.src_rob_i[s],
                               exc:     bus.src_exc_i[s],
                               mispred: bus.src_mispred_i[s]};
      end
    end
  end

  // FIFO pointers and counts; reset and flush both empty every source.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SRC; s++) begin
      if (reset || bus.flush_i) begin
        count[s]  <= '0;
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
      end else begin
        if (push[s])  wr_ptr[s] <= bump(wr_ptr[s]);
        if (grant[s]) rd_ptr[s] <= bump(rd_ptr[s]);
        case ({push[s], grant[s]})
          2'b10:   count[s] <= count[s] + CNT_W'(1);
          2'b01:   count[s] <= count[s] - CNT_W'(1);
          default: count[s] <= count[s];
        endcase
      end
    end
  end

  // Round-robin pointer moves past the last granted source; flush keeps it.
  always_ff @(posedge clock) begin
    if (reset) rr_ptr <= '0;
    else if (any_grant) rr_ptr <= next_rr;
  end

  assign bus.src_ready_o    = ready;
  assign bus.fu_valid_o     = lane_valid;
  assign bus.fu_value_o     = lane_value;
  assign bus.fu_dest_prf_o  = lane_dest;
  assign bus.fu_rob_idx_o   = lane_rob;
  assign bus.fu_exception_o = lane_exc;
  assign bus.fu_mispred_o   = lane_mispred;
  assign bus.dbg_rr_ptr     = rr_ptr;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed testbench for wb_arbiter.
module tb_wb_arbiter;
  localparam int XLEN = 32;
  localparam int PHYS_REGS = 128;
  localparam int ROB_DEPTH = 64;
  localparam int WB_WIDTH = 4;
  localparam int NUM_SRC = 6;
  localparam int BUF_DEPTH = 2;

  logic clk;
  logic rst;
  int checks = 0;
  int failures = 0;

  // Per-source expected result order for the saturation phase.
  logic [XLEN-1:0] exp_q [NUM_SRC][$];

  wb_arbiter_if #(.XLEN(XLEN), .PHYS_REGS(PHYS_REGS), .ROB_DEPTH(ROB_DEPTH),
                  .WB_WIDTH(WB_WIDTH), .NUM_SRC(NUM_SRC)) bus ();

  wb_arbiter #(.XLEN(XLEN), .PHYS_REGS(PHYS_REGS), .ROB_DEPTH(ROB_DEPTH),
               .WB_WIDTH(WB_WIDTH), .NUM_SRC(NUM_SRC), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clock(clk),
    .reset(rst),
    .bus(bus)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.flush_i = 1'b0;
    bus.src_valid_i = '0;
    for (int s = 0; s < NUM_SRC; s++) begin
      bus.src_value_i[s] = 'x;
      bus.src_dest_i[s] = 'x;
      bus.src_rob_i[s] = 'x;
      bus.src_exc_i[s] = 1'bx;
      bus.src_mispred_i[s] = 1'bx;
    end
  endtask

  task automatic drive(input int s, input logic [31:0] v, input logic [6:0] d,
                       input logic [5:0] r, input logic e, input logic m);
    bus.src_valid_i[s] = 1'b1;
    bus.src_value_i[s] = v;
    bus.src_dest_i[s] = d;
    bus.src_rob_i[s] = r;
    bus.src_exc_i[s] = e;
    bus.src_mispred_i[s] = m;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_lane(input string tag, input int l, input logic v,
                            input logic [31:0] val, input logic [6:0] d, input logic [5:0] r);
    check({tag, "_valid"}, 64'(bus.fu_valid_o[l]), 64'(v));
    check({tag, "_value"}, 64'(bus.fu_value_o[l]), 64'(val));
    check({tag, "_dest"}, 64'(bus.fu_dest_prf_o[l]), 64'(d));
    check({tag, "_rob"}, 64'(bus.fu_rob_idx_o[l]), 64'(r));
  endtask

  initial begin
    int seq [NUM_SRC];
    int miss [NUM_SRC];
    int pend [NUM_SRC];
    logic [NUM_SRC-1:0] granted;
    int pushed;
    int popped;
    int n_pend;
    int src;
    bit saw_stall;
    logic [XLEN-1:0] exp_v;

    // Reset with every source presenting a result.
    rst = 1'b1;
    clear_inputs();
    for (int s = 0; s < NUM_SRC; s++) drive(s, 32'h900 + 32'(s), 7'(s), 6'(s), 1'b1, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    check("rst_valid", 64'(bus.fu_valid_o), 64'h0);
    check("rst_ready", 64'(bus.src_ready_o), 64'h3f);
    check("rst_rr", 64'(bus.dbg_rr_ptr), 64'h0);
    for (int l = 0; l < WB_WIDTH; l++) check_lane("rst_lane", l, 1'b0, 32'h0, 7'h0, 6'h0);
    tick();
    check("rst_nothing_buffered", 64'(bus.fu_valid_o), 64'h0);

    // Back-to-back pushes from src0, in order and one cycle later.
    drive(0, 32'h11, 7'd5, 6'd3, 1'b0, 1'b0);
    #1;
    check("t2_no_bypass", 64'(bus.fu_valid_o), 64'h0);
    tick();
    drive(0, 32'h22, 7'd6, 6'd4, 1'b0, 1'b0);
    #1;
    check("t2_valid_a", 64'(bus.fu_valid_o), 64'h1);
    check_lane("t2_lane0_a", 0, 1'b1, 32'h11, 7'd5, 6'd3);
    check_lane("t2_lane1_a", 1, 1'b0, 32'h0, 7'h0, 6'h0);
    check_lane("t2_lane3_a", 3, 1'b0, 32'h0, 7'h0, 6'h0);
    check("t2_exc", 64'(bus.fu_exception_o), 64'h0);
    tick();
    clear_inputs();
    #1;
    check("t2_valid_b", 64'(bus.fu_valid_o), 64'h1);
    check_lane("t2_lane0_b", 0, 1'b1, 32'h22, 7'd6, 6'd4);
    check("t2_rr_b", 64'(bus.dbg_rr_ptr), 64'h1);
    tick();
    check("t2_empty", 64'(bus.fu_valid_o), 64'h0);

    // All six sources push once from rr_ptr = 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < NUM_SRC; s++) drive(s, 32'h100 + 32'(s), 7'(10 + s), 6'(20 + s), 1'b0, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("t3_valid_a", 64'(bus.fu_valid_o), 64'hf);
    check_lane("t3_l0", 0, 1'b1, 32'h100, 7'd10, 6'd20);
    check_lane("t3_l1", 1, 1'b1, 32'h101, 7'd11, 6'd21);
    check_lane("t3_l2", 2, 1'b1, 32'h102, 7'd12, 6'd22);
    check_lane("t3_l3", 3, 1'b1, 32'h103, 7'd13, 6'd23);
    tick();
    check("t3_rr_4", 64'(bus.dbg_rr_ptr), 64'h4);
    check("t3_valid_b", 64'(bus.fu_valid_o), 64'h3);
    check_lane("t3_l0b", 0, 1'b1, 32'h104, 7'd14, 6'd24);
    check_lane("t3_l1b", 1, 1'b1, 32'h105, 7'd15, 6'd25);
    check_lane("t3_l2b", 2, 1'b0, 32'h0, 7'h0, 6'h0);
    check_lane("t3_l3b", 3, 1'b0, 32'h0, 7'h0, 6'h0);
    tick();
    check("t3_rr_0", 64'(bus.dbg_rr_ptr), 64'h0);
    check("t3_valid_c", 64'(bus.fu_valid_o), 64'h0);

    // Saturation: all sources valid for 30 cycles, then drain.
    pushed = 0;
    popped = 0;
    saw_stall = 0;
    for (int s = 0; s < NUM_SRC; s++) begin
      seq[s] = 0;
      miss[s] = 0;
    end
    for (int cyc = 0; cyc < 40; cyc++) begin
      clear_inputs();
      if (cyc < 30) begin
        for (int s = 0; s < NUM_SRC; s++)
          drive(s, (32'(s) << 8) | 32'(seq[s]), 7'(s), 6'(seq[s]), 1'b0, 1'b0);
      end
      #1;
      n_pend = 0;
      for (int s = 0; s < NUM_SRC; s++) begin
        pend[s] = exp_q[s].size();
        if (pend[s] != 0) n_pend++;
      end
      if (n_pend > WB_WIDTH) n_pend = WB_WIDTH;
      check("t4_packed", 64'(bus.fu_valid_o), 64'((1 << n_pend) - 1));
      granted = '0;
      for (int l = 0; l < WB_WIDTH; l++) begin
        if (bus.fu_valid_o[l]) begin
          src = int'(bus.fu_value_o[l][15:8]);
          if (src < NUM_SRC && exp_q[src].size() != 0 && !granted[src]) begin
            exp_v = exp_q[src].pop_front();
            check("t4_order", 64'(bus.fu_value_o[l]), 64'(exp_v));
            check("t4_dest", 64'(bus.fu_dest_prf_o[l]), 64'(src));
            granted[src] = 1'b1;
            popped++;
          end else begin
            checks++;
            failures++;
            $error("FAIL t4_spurious observed=%0h expected=no_result", bus.fu_value_o[l]);
          end
        end
      end
      for (int s = 0; s < NUM_SRC; s++) begin
        if (granted[s]) miss[s] = 0;
        else if (pend[s] != 0) miss[s]++;
        if (pend[s] != 0) check("t4_fair", 64'(miss[s] < 2), 64'h1);
      end
      if (bus.src_ready_o != '1) saw_stall = 1;
      if (cyc < 30) begin
        for (int s = 0; s < NUM_SRC; s++) begin
          if (bus.src_ready_o[s]) begin
            exp_q[s].push_back((32'(s) << 8) | 32'(seq[s]));
            seq[s]++;
            pushed++;
          end
        end
      end
      tick();
    end
    clear_inputs();
    #1;
    check("t4_stall_seen", 64'(saw_stall), 64'h1);
    check("t4_no_loss", 64'(popped), 64'(pushed));
    for (int s = 0; s < NUM_SRC; s++) check("t4_drained", 64'(exp_q[s].size()), 64'h0);
    check("t4_ready_after", 64'(bus.src_ready_o), 64'h3f);

    // Flush with three buffered results and a same-cycle push.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(2, 32'h200, 7'd2, 6'd2, 1'b0, 1'b0);
    tick();
    clear_inputs();
    drive(0, 32'ha0, 7'd1, 6'd1, 1'b0, 1'b0);
    drive(2, 32'ha2, 7'd3, 6'd3, 1'b0, 1'b0);
    drive(3, 32'ha3, 7'd4, 6'd4, 1'b0, 1'b0);
    #1;
    check_lane("t5_pre", 0, 1'b1, 32'h200, 7'd2, 6'd2);
    tick();
    clear_inputs();
    bus.flush_i = 1'b1;
    drive(1, 32'h77, 7'd7, 6'd7, 1'b0, 1'b0);
    #1;
    check("t5_flush_valid", 64'(bus.fu_valid_o), 64'h0);
    check_lane("t5_flush_lane0", 0, 1'b0, 32'h0, 7'h0, 6'h0);
    check("t5_flush_rr", 64'(bus.dbg_rr_ptr), 64'h3);
    tick();
    clear_inputs();
    #1;
    check("t5_after_valid", 64'(bus.fu_valid_o), 64'h0);
    check("t5_after_ready", 64'(bus.src_ready_o), 64'h3f);
    check("t5_after_rr", 64'(bus.dbg_rr_ptr), 64'h3);
    tick();
    check("t5_no_77", 64'(bus.fu_valid_o), 64'h0);

    // LSQ-only grant wraps rr_ptr; flag bits pass through.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(5, 32'hdeadbeef, 7'd127, 6'd63, 1'b1, 1'b1);
    tick();
    clear_inputs();
    #1;
    check("t6_valid", 64'(bus.fu_valid_o), 64'h1);
    check_lane("t6_l0", 0, 1'b1, 32'hdeadbeef, 7'd127, 6'd63);
    check("t6_exc", 64'(bus.fu_exception_o), 64'h1);
    check("t6_mis", 64'(bus.fu_mispred_o), 64'h1);
    check_lane("t6_l1", 1, 1'b0, 32'h0, 7'h0, 6'h0);
    tick();
    check("t6_rr_wrap", 64'(bus.dbg_rr_ptr), 64'h0);
    drive(2, 32'h2222, 7'd22, 6'd12, 1'b0, 1'b1);
    tick();
    clear_inputs();
    #1;
    check_lane("t6_src2", 0, 1'b1, 32'h2222, 7'd22, 6'd12);
    check("t6_exc2", 64'(bus.fu_exception_o), 64'h0);
    check("t6_mis2", 64'(bus.fu_mispred_o), 64'h1);
    tick();
    check("t6_rr_3", 64'(bus.dbg_rr_ptr), 64'h3);
    drive(1, 32'h1111, 7'd11, 6'd1, 1'b0, 1'b0);
    drive(4, 32'h4444, 7'd44, 6'd4, 1'b1, 1'b0);
    tick();
    clear_inputs();
    #1;
    check("t6_valid_wrap", 64'(bus.fu_valid_o), 64'h3);
    check_lane("t6_wrap_l0", 0, 1'b1, 32'h4444, 7'd44, 6'd4);
    check_lane("t6_wrap_l1", 1, 1'b1, 32'h1111, 7'd11, 6'd1);
    check("t6_exc_wrap", 64'(bus.fu_exception_o), 64'h1);
    tick();
    check("t6_rr_2", 64'(bus.dbg_rr_ptr), 64'h2);
    check("t6_end_valid", 64'(bus.fu_valid_o), 64'h0);

    // Final report.
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
